nettlp_tx_encap: RTL and testbench

Wraps TLPs pulled from the PCIE_RX FIFO (PCIE_FIFO64_RX entries) into Ethernet/IPv4/UDP/NetTLP frames and emits them as a 64-bit AXI4-Stream to the 10G Ethernet subsystem TX port. It sits between the PCIe-side RX FIFO read port and the MAC. It builds the 48-byte header (6 qwords, ETH_TDATA64 clk0..clk5 layouts), then streams the TLP qwords unmodified except for byte-lane ordering.

---
 rtl/nettlp_pkg.sv | 74 +++++++
 rtl/nettlp_ip_csum.sv | 38 +++
 rtl/nettlp_tx_encap.sv | 168 ++++++++++++++++
 tb/tb_nettlp_tx_encap.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nettlp_pkg.sv
// Shared NetTLP TX types: FIFO entry layout, header qword layouts, protocol constants.
package nettlp_pkg;

  localparam int unsigned PACKET_HDR_LEN    = 48;
  localparam int unsigned PACKET_HDR_QWORDS = PACKET_HDR_LEN / 8;

  localparam logic [15:0] ETH_P_IP     = 16'h0800;
  localparam logic [7:0]  IPPROTO_UDP  = 8'd17;
  localparam logic [15:0] IP_FRAG_DF   = 16'h4000;
  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  // IP(20)+UDP(8)+NetTLP(6) and UDP(8)+NetTLP(6) added to the TLP byte length
  localparam logic [15:0] IP_LEN_BASE  = 16'd34;
  localparam logic [15:0] UDP_LEN_BASE = 16'd14;

  typedef enum logic [1:0] {IDLE, HDR, BODY} tx_state_t;

  typedef logic [63:0] ETH_TDATA64;

  typedef struct packed {
    logic [22:0] rsvd;
    logic [10:0] tlp_len;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
  } PCIE_FIFO64_RX;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [15:0] src_mac_hi;
  } PACKET_QWORD0;

  typedef struct packed {
    logic [31:0] src_mac_lo;
    logic [15:0] ethertype;
    logic [7:0]  ver_ihl;
    logic [7:0]  tos;
  } PACKET_QWORD1;

  typedef struct packed {
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [15:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
  } PACKET_QWORD2;

  typedef struct packed {
    logic [15:0] check;
    logic [31:0] src_ip;
    logic [15:0] dst_ip_hi;
  } PACKET_QWORD3;

  typedef struct packed {
    logic [15:0] dst_ip_lo;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
  } PACKET_QWORD4;

  typedef struct packed {
    logic [15:0] udp_check;
    logic [15:0] pktseq;
    logic [31:0] tstamp;
  } PACKET_QWORD5;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    return {bswap32(x[31:0]), bswap32(x[63:32])};
  endfunction

endpackage

// File: rtl/nettlp_ip_csum.sv
// Two-stage IPv4 header checksum over the latched per-packet fields.
module nettlp_ip_csum
  import nettlp_pkg::*;
#(
  parameter logic [7:0] TTL = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] tot_len,
  output logic [15:0] check
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
  end

  // id and checksum words are zero and drop out of the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      check <= '0;
    end else begin
      sum   <= 20'({IP_VER_IHL, 8'h00}) + 20'(tot_len) + 20'(IP_FRAG_DF)
             + 20'({TTL, IPPROTO_UDP})
             + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
             + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
      check <= ~fold2;
    end
  end

endmodule

// File: rtl/nettlp_tx_encap.sv
// Wraps FIFO TLPs into Ethernet/IPv4/UDP/NetTLP frames on a 64-bit AXI4-Stream.
// Optional macro NETTLP_TSTAMP_EN: carry tstamp_in in the NetTLP header (else 0).
module nettlp_tx_encap
  import nettlp_pkg::*;
#(
  parameter logic [7:0]  TTL      = 8'd64,
  parameter int unsigned PKTSEQ_W = 10
) (
  input  logic         clk156,
  input  logic         sys_rst_n,
  input  logic [106:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [47:0]  cfg_src_mac,
  input  logic [47:0]  cfg_dst_mac,
  input  logic [31:0]  cfg_src_ip,
  input  logic [31:0]  cfg_dst_ip,
  input  logic [15:0]  cfg_src_port,
  input  logic [15:0]  cfg_dst_port,
  input  logic [31:0]  tstamp_in,
  input  logic         m_axis_tready,
  output logic         m_axis_tvalid,
  output logic [63:0]  m_axis_tdata,
  output logic [7:0]   m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic         m_axis_tuser,
  output logic         err_underrun
);

  tx_state_t           state;
  logic [2:0]          qidx;
  logic [PKTSEQ_W-1:0] seq;
  PCIE_FIFO64_RX       head;

  logic [47:0] hdr_src_mac, hdr_dst_mac;
  logic [31:0] hdr_src_ip, hdr_dst_ip;
  logic [15:0] hdr_src_port, hdr_dst_port;
  logic [15:0] hdr_tot_len, hdr_udp_len;
  logic [31:0] hdr_tstamp;
  logic [15:0] ip_check;

  PACKET_QWORD0 q0;
  PACKET_QWORD1 q1;
  PACKET_QWORD2 q2;
  PACKET_QWORD3 q3;
  PACKET_QWORD4 q4;
  PACKET_QWORD5 q5;
  ETH_TDATA64   hdr_qword;

  logic unused_fifo;

  assign head        = fifo_dout;
  assign unused_fifo = ^head.rsvd;

`ifdef NETTLP_TSTAMP_EN
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n)
      hdr_tstamp <= '0;
    else if (state == IDLE && !fifo_empty)
      hdr_tstamp <= tstamp_in;
  end
`else
  logic unused_tstamp;
  assign unused_tstamp = ^tstamp_in;
  assign hdr_tstamp    = '0;
`endif

  nettlp_ip_csum #(.TTL(TTL)) u_csum (
    .clk     (clk156),
    .rst_n   (sys_rst_n),
    .src_ip  (hdr_src_ip),
    .dst_ip  (hdr_dst_ip),
    .tot_len (hdr_tot_len),
    .check   (ip_check)
  );

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      qidx         <= '0;
      seq          <= '0;
      hdr_src_mac  <= '0;
      hdr_dst_mac  <= '0;
      hdr_src_ip   <= '0;
      hdr_dst_ip   <= '0;
      hdr_src_port <= '0;
      hdr_dst_port <= '0;
      hdr_tot_len  <= '0;
      hdr_udp_len  <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          hdr_src_mac  <= cfg_src_mac;
          hdr_dst_mac  <= cfg_dst_mac;
          hdr_src_ip   <= cfg_src_ip;
          hdr_dst_ip   <= cfg_dst_ip;
          hdr_src_port <= cfg_src_port;
          hdr_dst_port <= cfg_dst_port;
          hdr_tot_len  <= IP_LEN_BASE + 16'(head.tlp_len);
          hdr_udp_len  <= UDP_LEN_BASE + 16'(head.tlp_len);
          qidx         <= '0;
          state        <= HDR;
        end
        HDR: if (m_axis_tready) begin
          if (qidx == 3'(PACKET_HDR_QWORDS - 1)) begin
            qidx  <= '0;
            state <= BODY;
          end else begin
            qidx <= qidx + 3'd1;
          end
        end
        BODY: if (m_axis_tready && !fifo_empty && head.tlast) begin
          seq   <= seq + PKTSEQ_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    q0 = '{dst_mac: hdr_dst_mac, src_mac_hi: hdr_src_mac[47:32]};
    q1 = '{src_mac_lo: hdr_src_mac[31:0], ethertype: ETH_P_IP,
           ver_ihl: IP_VER_IHL, tos: 8'h00};
    q2 = '{tot_len: hdr_tot_len, id: 16'h0000, frag_off: IP_FRAG_DF,
           ttl: TTL, protocol: IPPROTO_UDP};
    q3 = '{check: ip_check, src_ip: hdr_src_ip, dst_ip_hi: hdr_dst_ip[31:16]};
    q4 = '{dst_ip_lo: hdr_dst_ip[15:0], src_port: hdr_src_port,
           dst_port: hdr_dst_port, udp_len: hdr_udp_len};
    q5 = '{udp_check: 16'h0000, pktseq: 16'(seq), tstamp: hdr_tstamp};
    case (qidx)
      3'd0:    hdr_qword = q0;
      3'd1:    hdr_qword = q1;
      3'd2:    hdr_qword = q2;
      3'd3:    hdr_qword = q3;
      3'd4:    hdr_qword = q4;
      default: hdr_qword = q5;
    endcase
  end

  // Outputs decode from registered state so reset forces them low at once
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    fifo_rd_en    = 1'b0;
    err_underrun  = 1'b0;
    case (state)
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = bswap64(hdr_qword);
        m_axis_tkeep  = '1;
      end
      BODY: begin
        m_axis_tvalid = !fifo_empty;
        m_axis_tdata  = {bswap32(head.tdata[63:32]), bswap32(head.tdata[31:0])};
        m_axis_tkeep  = head.tkeep;
        m_axis_tlast  = head.tlast;
        fifo_rd_en    = m_axis_tready && !fifo_empty;
        err_underrun  = fifo_empty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nettlp_tx_encap.sv
// Directed bench for nettlp_tx_encap: vector table plus multi-cycle corner sequences.
module tb_nettlp_tx_encap;

  logic         clk156 = 1'b0;
  logic         sys_rst_n;
  logic [106:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [47:0]  cfg_src_mac, cfg_dst_mac;
  logic [31:0]  cfg_src_ip, cfg_dst_ip;
  logic [15:0]  cfg_src_port, cfg_dst_port;
  logic [31:0]  tstamp_in;
  logic         m_axis_tready;
  logic         m_axis_tvalid;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tuser;
  logic         err_underrun;

  always #3 clk156 = ~clk156;

  nettlp_tx_encap #(.TTL(8'd64), .PKTSEQ_W(10)) dut (
    .clk156        (clk156),
    .sys_rst_n     (sys_rst_n),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .cfg_src_mac   (cfg_src_mac),
    .cfg_dst_mac   (cfg_dst_mac),
    .cfg_src_ip    (cfg_src_ip),
    .cfg_dst_ip    (cfg_dst_ip),
    .cfg_src_port  (cfg_src_port),
    .cfg_dst_port  (cfg_dst_port),
    .tstamp_in     (tstamp_in),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .err_underrun  (err_underrun)
  );

  // FWFT FIFO model: entry = {rsvd23, tlp_len11, tlast, tkeep8, tdata64}
  logic [106:0] mem [0:2047];
  int   wr_cnt = 0;
  int   rd_ptr = 0;
  logic force_empty = 1'b0;
  logic flush = 1'b0;

  assign fifo_empty = force_empty || (rd_ptr == wr_cnt);
  assign fifo_dout  = mem[rd_ptr[10:0]];

  always @(posedge clk156) begin
    if (flush) rd_ptr <= wr_cnt;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  // Stream monitor, sampled mid-cycle
  logic [63:0] cap_d [$];
  logic [7:0]  cap_k [$];
  logic        cap_l [$];
  int          gap_q [$];
  int   rd_cnt = 0, uf_cnt = 0, hold_bad = 0, hold_seen = 0, idle_run = 0;
  logic in_frame = 1'b0, stalled = 1'b0;
  logic [72:0] prev_beat = '0;

  always @(negedge clk156) begin
    if (!sys_rst_n) begin
      stalled  <= 1'b0;
      in_frame <= 1'b0;
      idle_run <= 0;
    end else begin
      if (stalled) begin
        hold_seen <= hold_seen + 1;
        if (!m_axis_tvalid || {m_axis_tdata, m_axis_tkeep, m_axis_tlast} != prev_beat)
          hold_bad <= hold_bad + 1;
      end
      stalled   <= m_axis_tvalid && !m_axis_tready;
      prev_beat <= {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (fifo_rd_en)   rd_cnt <= rd_cnt + 1;
      if (err_underrun) uf_cnt <= uf_cnt + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (!in_frame) gap_q.push_back(idle_run);
        cap_d.push_back(m_axis_tdata);
        cap_k.push_back(m_axis_tkeep);
        cap_l.push_back(m_axis_tlast);
        in_frame <= !m_axis_tlast;
        if (m_axis_tlast) idle_run <= 0;
      end else if (!m_axis_tvalid && !in_frame) begin
        idle_run <= idle_run + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk156);
    #1;
  endtask

  // Expected-packet model state
  logic [63:0] body_d [0:7];
  logic [7:0]  eh [0:47];
  logic [15:0] e_len;
  logic [9:0]  e_seq;
  logic [31:0] e_ts;

  task automatic build_hdr();
    logic [31:0] s;
    for (int i = 0; i < 6; i++) eh[i]     = cfg_dst_mac[47-8*i -: 8];
    for (int i = 0; i < 6; i++) eh[6+i]   = cfg_src_mac[47-8*i -: 8];
    eh[12] = 8'h08; eh[13] = 8'h00; eh[14] = 8'h45; eh[15] = 8'h00;
    {eh[16], eh[17]} = 16'd34 + e_len;
    {eh[18], eh[19]} = 16'h0000;
    {eh[20], eh[21]} = 16'h4000;
    eh[22] = 8'd64; eh[23] = 8'd17;
    {eh[24], eh[25]} = 16'h0000;
    for (int i = 0; i < 4; i++) eh[26+i] = cfg_src_ip[31-8*i -: 8];
    for (int i = 0; i < 4; i++) eh[30+i] = cfg_dst_ip[31-8*i -: 8];
    {eh[34], eh[35]} = cfg_src_port;
    {eh[36], eh[37]} = cfg_dst_port;
    {eh[38], eh[39]} = 16'd14 + e_len;
    {eh[40], eh[41]} = 16'h0000;
    {eh[42], eh[43]} = {6'b0, e_seq};
    for (int i = 0; i < 4; i++) eh[44+i] = e_ts[31-8*i -: 8];
    s = 0;
    for (int k = 0; k < 10; k++) s = s + {16'h0, eh[14+2*k], eh[15+2*k]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    {eh[24], eh[25]} = ~s[15:0];
  endtask

  task automatic push_pkt(input int nq);
    for (int q = 0; q < nq; q++) begin
      mem[wr_cnt[10:0]] = {23'h0, 11'(nq*8), (q == nq-1), 8'hFF, body_d[q]};
      wr_cnt++;
    end
  endtask

  task automatic wait_beats(input int base, input int n, input int bound);
    int t = 0;
    while (cap_d.size() < base + n && t < bound) begin
      step();
      t++;
    end
    chk("beat_timeout", 128'(cap_d.size() >= base + n), 128'd1);
  endtask

  task automatic check_frame(input int base, input int nq);
    logic [63:0] e;
    build_hdr();
    for (int b = 0; b < 6 + nq; b++) begin
      for (int j = 0; j < 8; j++)
        e[8*j +: 8] = (b < 6) ? eh[8*b+j] : body_d[b-6][8*(j^3) +: 8];
      chk($sformatf("frame_beat%0d", b),
          {55'h0, cap_d[base+b], cap_k[base+b], cap_l[base+b]},
          {55'h0, e, 8'hFF, (b == 5 + nq)});
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    flush     = 1'b1;
    step(); step();
    sys_rst_n = 1'b1;
    flush     = 1'b0;
    step();
  endtask

  typedef struct {
    logic [31:0] sip;
    logic [31:0] dip;
    int          nq;
    logic [15:0] exp_tot;
    logic [15:0] exp_udp;
    logic [15:0] exp_csum;
  } vec_t;

  vec_t vt [3];

  initial begin
    int base, rb, ub, hb, hs, gb, bad;
    logic [63:0] w;

    vt[0] = '{32'hC0A80A01, 32'hC0A80A03, 2, 16'h0032, 16'h001E, 16'hA566};
    vt[1] = '{32'h0A000001, 32'h0A000002, 1, 16'h002A, 16'h0016, 16'h26C1};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3, 16'h003A, 16'h0026, 16'h3AB4};

`ifdef NETTLP_TSTAMP_EN
    e_ts = 32'hDEADBEEF;
`else
    e_ts = 32'h0;
`endif
    sys_rst_n     = 1'b0;
    m_axis_tready = 1'b1;
    cfg_dst_mac   = 48'h001122334455;
    cfg_src_mac   = 48'h02AABBCCDDEE;
    cfg_src_ip    = 32'h0;
    cfg_dst_ip    = 32'h0;
    cfg_src_port  = 16'h3039;
    cfg_dst_port  = 16'h3039;
    tstamp_in     = 32'hDEADBEEF;
    e_seq         = '0;
    for (int i = 0; i < 8; i++) body_d[i] = 64'h1111_0000_0000_0000 * 64'(i + 1) + 64'(i);
    step(); step();
    chk("reset_outputs",
        {55'h0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser, fifo_rd_en, err_underrun},
        128'h0);
    sys_rst_n = 1'b1;
    step(); step();

    // Checksum / length / byte-order table
    for (int v = 0; v < 3; v++) begin
      cfg_src_ip = vt[v].sip;
      cfg_dst_ip = vt[v].dip;
      e_len      = 16'(vt[v].nq * 8);
      body_d[0]  = (v == 0) ? 64'h0A0B0C0D_01020304 : 64'h1111_0000_0000_0000 + 64'(v);
      base = cap_d.size();
      push_pkt(vt[v].nq);
      @(negedge clk156);
      chk($sformatf("v%0d_latency_idle", v), 128'(m_axis_tvalid), 128'd0);
      @(negedge clk156);
      chk($sformatf("v%0d_latency_hdr0", v), 128'(m_axis_tvalid), 128'd1);
      wait_beats(base, 6 + vt[v].nq, 100);
      chk($sformatf("v%0d_tot_len", v), 128'({cap_d[base+2][7:0], cap_d[base+2][15:8]}), 128'(vt[v].exp_tot));
      chk($sformatf("v%0d_ip_check", v), 128'({cap_d[base+3][7:0], cap_d[base+3][15:8]}), 128'(vt[v].exp_csum));
      chk($sformatf("v%0d_udp_len", v), 128'({cap_d[base+4][55:48], cap_d[base+4][63:56]}), 128'(vt[v].exp_udp));
      bad = 0;
      for (int b = 0; b < 6 + vt[v].nq; b++) bad += (cap_l[base+b] != (b == 5 + vt[v].nq)) ? 1 : 0;
      chk($sformatf("v%0d_tlast_pos", v), 128'(bad), 128'd0);
      check_frame(base, vt[v].nq);
      if (v == 0) begin
        chk("bo_dstmac_first", 128'(cap_d[base][7:0]), 128'h00);
        chk("bo_dstmac_last", 128'(cap_d[base][47:40]), 128'h55);
        chk("bo_body", 128'(cap_d[base+6]), 128'h0D0C0B0A_04030201);
        w = cap_d[base+5];
        chk("tstamp", 128'({w[39:32], w[47:40], w[55:48], w[63:56]}), 128'(e_ts));
      end
      e_seq = e_seq + 10'd1;
      step(); step();
    end

    // Backpressure: tready toggles across a 3-qword TLP
    e_len = 16'd24;
    base = cap_d.size(); rb = rd_cnt; hb = hold_bad; hs = hold_seen;
    push_pkt(3);
    for (int t = 0; t < 200 && cap_d.size() < base + 9; t++) begin
      step();
      m_axis_tready = ~m_axis_tready;
    end
    m_axis_tready = 1'b1;
    wait_beats(base, 9, 20);
    step();
    chk("bp_rd_en_count", 128'(rd_cnt - rb), 128'd3);
    chk("bp_hold_violations", 128'(hold_bad - hb), 128'd0);
    chk("bp_stalls_seen", 128'(hold_seen > hs), 128'd1);
    check_frame(base, 3);
    e_seq = e_seq + 10'd1;
    step();

    // Underrun: FIFO forced empty for two cycles mid-body
    e_len = 16'd32;
    base = cap_d.size(); rb = rd_cnt; ub = uf_cnt;
    push_pkt(4);
    for (int t = 0; t < 100 && rd_cnt < rb + 1; t++) step();
    force_empty = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk156);
      chk($sformatf("ur_tvalid_c%0d", c), 128'(m_axis_tvalid), 128'd0);
      chk($sformatf("ur_flag_c%0d", c), 128'(err_underrun), 128'd1);
      step();
    end
    force_empty = 1'b0;
    wait_beats(base, 10, 50);
    step();
    chk("ur_pulse_count", 128'(uf_cnt - ub), 128'd2);
    chk("ur_rd_en_count", 128'(rd_cnt - rb), 128'd4);
    check_frame(base, 4);
    e_seq = e_seq + 10'd1;

    // Reset mid-header, then restart at qword 0 with pktseq 0
    e_len = 16'd16;
    base = cap_d.size(); rb = rd_cnt;
    push_pkt(2);
    wait_beats(base, 2, 50);
    sys_rst_n = 1'b0;
    flush     = 1'b1;
    #1;
    chk("rst_mid_outputs",
        {55'h0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser, fifo_rd_en, err_underrun},
        128'h0);
    step(); step();
    sys_rst_n = 1'b1;
    flush     = 1'b0;
    step();
    chk("rst_no_pop", 128'(rd_cnt - rb), 128'd0);
    e_seq = '0;
    base = cap_d.size();
    push_pkt(2);
    wait_beats(base, 8, 50);
    check_frame(base, 2);

    // Sequence wrap: 1025 back-to-back 1-qword TLPs from a fresh reset
    step();
    do_reset();
    e_len = 16'd8;
    base = cap_d.size(); gb = gap_q.size();
    for (int k = 0; k < 1025; k++) begin
      body_d[0] = 64'hC0DE_0000_0000_0000 + 64'(k);
      push_pkt(1);
    end
    wait_beats(base, 7 * 1025, 12000);
    bad = 0;
    for (int k = 0; k < 1025; k++) begin
      w = cap_d[base + 7*k + 5];
      if ({w[23:16], w[31:24]} != 16'(k % 1024)) bad++;
      if (!cap_l[base + 7*k + 6] || cap_l[base + 7*k + 5]) bad++;
    end
    chk("wrap_seq_and_tlast", 128'(bad), 128'd0);
    bad = 0;
    for (int k = 1; k < 1025; k++) if (gap_q[gb + k] != 1) bad++;
    chk("wrap_idle_gap", 128'(bad), 128'd0);
    e_seq = '0;
    check_frame(base + 7*1024, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
